// File: rtl/ball_motion_sched_pkg.sv
// ---------------------------------------------------------------------------
// ball_sched_pkg
// Shared types and defaults for the ball motion scheduler.
//   state_t       : scan controller states (IDLE/CALC/COMMIT/DONE)
//   DEF_INIT_POS  : default reset position of every object (H and V)
//   DEF_OBJ_SIZE  : default ball size in pixels
//   RST_HVEL/VVEL : velocities loaded into every object on reset
// ---------------------------------------------------------------------------
package ball_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_INIT_POS = 128;
  localparam int DEF_OBJ_SIZE = 4;
  localparam int RST_HVEL     = -2;
  localparam int RST_VVEL     = 2;

endpackage

// File: rtl/ball_motion_sched_if.sv
// ---------------------------------------------------------------------------
// ball_motion_sched_if
// Object-state load port of the ball scheduler (valid/ready handshake).
//   cfg_valid  : write request (master -> slave)
//   cfg_ready  : write accepted when high together with cfg_valid
//   cfg_idx    : target object index (out-of-range indices are ignored)
//   cfg_hpos/cfg_vpos/cfg_hvel/cfg_vvel : new object state, COORD_W bits each
// ---------------------------------------------------------------------------
interface ball_motion_sched_if #(
  parameter int COORD_W = 9
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [2:0]         cfg_idx;
  logic [COORD_W-1:0] cfg_hpos;
  logic [COORD_W-1:0] cfg_vpos;
  logic [COORD_W-1:0] cfg_hvel;
  logic [COORD_W-1:0] cfg_vvel;

  modport master (
    output cfg_valid, cfg_idx, cfg_hpos, cfg_vpos, cfg_hvel, cfg_vvel,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_idx, cfg_hpos, cfg_vpos, cfg_hvel, cfg_vvel,
    output cfg_ready
  );
endinterface

// File: rtl/ball_motion_sched_axis_step.sv
// ---------------------------------------------------------------------------
// ball_axis_step
// Combinational single-axis step with wall bounce.
//   i_pos  : current position (unsigned)
//   i_vel  : current velocity (two's complement)
//   i_lim  : playfield extent on this axis; the far wall sits at
//            i_lim - OBJ_SIZE so the whole ball stays visible
//   o_pos  : next position
//   o_vel  : next velocity (negated on a bounce)
//   o_col  : high when this step bounced
// ---------------------------------------------------------------------------
module ball_axis_step #(
  parameter int COORD_W  = 9,
  parameter int OBJ_SIZE = 4
) (
  input  logic [COORD_W-1:0] i_pos,
  input  logic [COORD_W-1:0] i_vel,
  input  logic [COORD_W-1:0] i_lim,
  output logic [COORD_W-1:0] o_pos,
  output logic [COORD_W-1:0] o_vel,
  output logic               o_col
);

  logic [COORD_W-1:0] w_sum;
  logic [COORD_W-1:0] w_bound;
  logic [COORD_W-1:0] w_vel_neg;
  logic               w_vel_is_neg;
  logic               w_vel_is_pos;

  // Wrapping add; the bounce tests below decide whether the wrap matters.
  assign w_sum        = i_pos + i_vel;
  assign w_bound      = i_lim - COORD_W'(OBJ_SIZE);
  assign w_vel_neg    = -i_vel;
  assign w_vel_is_neg = i_vel[COORD_W-1];
  assign w_vel_is_pos = !i_vel[COORD_W-1] && (i_vel != '0);

  always_comb begin
    o_pos = w_sum;
    o_vel = i_vel;
    o_col = 1'b0;
    if (w_vel_is_pos && (w_sum >= w_bound)) begin
      o_pos = w_bound;
      o_vel = w_vel_neg;
      o_col = 1'b1;
    end else if (w_vel_is_neg && (i_pos < w_vel_neg)) begin
      // Moving left/up past zero: the add borrowed, so pin to the wall.
      o_pos = '0;
      o_vel = w_vel_neg;
      o_col = 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_sched.sv
// ---------------------------------------------------------------------------
// ball_motion_sched
// Frame-rate motion scheduler for NUM_OBJ bouncing balls. One H and one V
// step unit are shared; after each vsync rising edge the objects are walked
// one at a time (CALC then COMMIT per object), followed by a DONE cycle.
//
// Ports:
//   clk        : pixel clock
//   reset      : asynchronous active-low reset
//   vsync      : raw vsync, synchronised internally
//   pause      : (only with BALL_SCHED_PAUSE_EN) drop vsync edges seen in IDLE
//   cfg        : object-state load port (ball_motion_sched_if.slave)
//   obj_hpos/obj_vpos : packed positions, object i at [i*COORD_W +: COORD_W]
//   obj_hcol/obj_vcol : bounce flags from each object's last update
//   busy       : high from first CALC through DONE
//   frame_done : one-cycle pulse during DONE
//   overrun    : sticky, a vsync edge was lost (cleared only by reset)
//
// Build option: define BALL_SCHED_PAUSE_EN to add the pause input.
// ---------------------------------------------------------------------------
module ball_motion_sched #(
  parameter int NUM_OBJ  = 4,
  parameter int COORD_W  = 9,
  parameter int H_LIMIT  = 300,
  parameter int V_LIMIT  = 300,
  parameter int OBJ_SIZE = ball_sched_pkg::DEF_OBJ_SIZE,
  parameter int INIT_POS = ball_sched_pkg::DEF_INIT_POS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vsync,
`ifdef BALL_SCHED_PAUSE_EN
  input  logic                       pause,
`endif
  ball_motion_sched_if.slave         cfg,
  output logic [NUM_OBJ*COORD_W-1:0] obj_hpos,
  output logic [NUM_OBJ*COORD_W-1:0] obj_vpos,
  output logic [NUM_OBJ-1:0]         obj_hcol,
  output logic [NUM_OBJ-1:0]         obj_vcol,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun
);
  import ball_sched_pkg::*;

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [COORD_W-1:0] INIT_P  = COORD_W'(INIT_POS);
  localparam logic [COORD_W-1:0] INIT_HV = COORD_W'(RST_HVEL);
  localparam logic [COORD_W-1:0] INIT_VV = COORD_W'(RST_VVEL);
  localparam logic [COORD_W-1:0] H_LIM   = COORD_W'(H_LIMIT);
  localparam logic [COORD_W-1:0] V_LIM   = COORD_W'(V_LIMIT);

  // Object state
  logic [COORD_W-1:0] r_hpos [NUM_OBJ];
  logic [COORD_W-1:0] r_vpos [NUM_OBJ];
  logic [COORD_W-1:0] r_hvel [NUM_OBJ];
  logic [COORD_W-1:0] r_vvel [NUM_OBJ];
  logic               r_hcol [NUM_OBJ];
  logic               r_vcol [NUM_OBJ];

  // Control
  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_pending;
  logic               r_overrun;
  logic               r_busy;
  logic               r_frame_done;
  logic               r_vs_meta;
  logic               r_vs_sync;
  logic               r_vs_prev;
  logic               r_vs_edge;

  // Results captured in CALC, written back in COMMIT
  logic [COORD_W-1:0] r_nh_pos, r_nh_vel, r_nv_pos, r_nv_vel;
  logic               r_nh_col, r_nv_col;

  logic [COORD_W-1:0] w_cur_hpos, w_cur_vpos, w_cur_hvel, w_cur_vvel;
  logic [COORD_W-1:0] w_h_pos, w_h_vel, w_v_pos, w_v_vel;
  logic               w_h_col, w_v_col;
  logic               w_last;
  logic               w_take;
  logic               w_pause_drop;
  logic               w_edge_accept;
  logic               w_cfg_fire;
  logic [NUM_OBJ-1:0] w_cfg_hit;
  logic [NUM_OBJ-1:0] w_commit_hit;

`ifdef BALL_SCHED_PAUSE_EN
  // Only edges seen while idle are dropped; a running scan still finishes
  // and an edge arriving during it is queued as usual.
  assign w_pause_drop = pause && (r_state == IDLE);
`else
  assign w_pause_drop = 1'b0;
`endif

  assign w_last        = (r_idx == IDX_W'(NUM_OBJ - 1));
  assign w_take        = (r_state == IDLE) && r_pending;
  assign w_edge_accept = r_vs_edge && !w_pause_drop;
  assign cfg.cfg_ready = (r_state == IDLE);
  assign w_cfg_fire    = cfg.cfg_valid && (r_state == IDLE);

  assign w_cur_hpos = r_hpos[r_idx];
  assign w_cur_vpos = r_vpos[r_idx];
  assign w_cur_hvel = r_hvel[r_idx];
  assign w_cur_vvel = r_vvel[r_idx];

  ball_axis_step #(.COORD_W(COORD_W), .OBJ_SIZE(OBJ_SIZE)) u_step_h (
    .i_pos (w_cur_hpos),
    .i_vel (w_cur_hvel),
    .i_lim (H_LIM),
    .o_pos (w_h_pos),
    .o_vel (w_h_vel),
    .o_col (w_h_col)
  );

  ball_axis_step #(.COORD_W(COORD_W), .OBJ_SIZE(OBJ_SIZE)) u_step_v (
    .i_pos (w_cur_vpos),
    .i_vel (w_cur_vvel),
    .i_lim (V_LIM),
    .o_pos (w_v_pos),
    .o_vel (w_v_vel),
    .o_col (w_v_col)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_pending) w_state_next = CALC;
      CALC:    w_state_next = COMMIT;
      COMMIT:  w_state_next = w_last ? DONE : CALC;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_vs_meta    <= 1'b0;
      r_vs_sync    <= 1'b0;
      r_vs_prev    <= 1'b0;
      r_vs_edge    <= 1'b0;
      r_nh_pos     <= '0;
      r_nh_vel     <= '0;
      r_nv_pos     <= '0;
      r_nv_vel     <= '0;
      r_nh_col     <= 1'b0;
      r_nv_col     <= 1'b0;
    end else begin
      r_vs_meta <= vsync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
      r_vs_edge <= r_vs_sync && !r_vs_prev;

      r_state <= w_state_next;

      if (w_take) begin
        r_idx <= '0;
      end else if ((r_state == COMMIT) && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end

      // An edge that finds a scan already queued is lost, even when the
      // queued scan is being launched in this same cycle.
      if (w_take) begin
        r_pending <= 1'b0;
      end else if (w_edge_accept) begin
        r_pending <= 1'b1;
      end
      if (w_edge_accept && r_pending) begin
        r_overrun <= 1'b1;
      end

      if (r_state == CALC) begin
        r_nh_pos <= w_h_pos;
        r_nh_vel <= w_h_vel;
        r_nh_col <= w_h_col;
        r_nv_pos <= w_v_pos;
        r_nv_vel <= w_v_vel;
        r_nv_col <= w_v_col;
      end

      r_busy       <= (w_state_next != IDLE);
      r_frame_done <= (w_state_next == DONE);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
      assign w_cfg_hit[gi]    = w_cfg_fire && (cfg.cfg_idx == 3'(gi));
      assign w_commit_hit[gi] = (r_state == COMMIT) && (r_idx == IDX_W'(gi));

      // Config writes only happen in IDLE and commits only in COMMIT,
      // so the two update sources never collide.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_hpos[gi] <= INIT_P;
          r_vpos[gi] <= INIT_P;
          r_hvel[gi] <= INIT_HV;
          r_vvel[gi] <= INIT_VV;
          r_hcol[gi] <= 1'b0;
          r_vcol[gi] <= 1'b0;
        end else if (w_cfg_hit[gi]) begin
          r_hpos[gi] <= cfg.cfg_hpos;
          r_vpos[gi] <= cfg.cfg_vpos;
          r_hvel[gi] <= cfg.cfg_hvel;
          r_vvel[gi] <= cfg.cfg_vvel;
          r_hcol[gi] <= 1'b0;
          r_vcol[gi] <= 1'b0;
        end else if (w_commit_hit[gi]) begin
          r_hpos[gi] <= r_nh_pos;
          r_vpos[gi] <= r_nv_pos;
          r_hvel[gi] <= r_nh_vel;
          r_vvel[gi] <= r_nv_vel;
          r_hcol[gi] <= r_nh_col;
          r_vcol[gi] <= r_nv_col;
        end
      end

      assign obj_hpos[gi*COORD_W +: COORD_W] = r_hpos[gi];
      assign obj_vpos[gi*COORD_W +: COORD_W] = r_vpos[gi];
      assign obj_hcol[gi] = r_hcol[gi];
      assign obj_vcol[gi] = r_vcol[gi];
    end
  endgenerate

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_ball_motion_sched.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_sched
// Directed, table-driven bench for ball_motion_sched (NUM_OBJ = 4,
// COORD_W = 9, 300x300 playfield, OBJ_SIZE = 4, so both walls sit at 296).
// Define BALL_SCHED_PAUSE_EN to also exercise the pause input.
// ---------------------------------------------------------------------------
module tb_ball_motion_sched;
  localparam int NUM_OBJ = 4;
  localparam int COORD_W = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic vsync = 1'b0;
`ifdef BALL_SCHED_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic [NUM_OBJ*COORD_W-1:0] obj_hpos, obj_vpos;
  logic [NUM_OBJ-1:0]         obj_hcol, obj_vcol;
  logic                       busy, frame_done, overrun;

  ball_motion_sched_if #(.COORD_W(COORD_W)) cfg_bus ();

  ball_motion_sched #(
    .NUM_OBJ (NUM_OBJ),
    .COORD_W (COORD_W),
    .H_LIMIT (300),
    .V_LIMIT (300),
    .OBJ_SIZE(4),
    .INIT_POS(128)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
`ifdef BALL_SCHED_PAUSE_EN
    .pause     (pause),
`endif
    .cfg       (cfg_bus),
    .obj_hpos  (obj_hpos),
    .obj_vpos  (obj_vpos),
    .obj_hcol  (obj_hcol),
    .obj_vcol  (obj_vcol),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int idx;
    int hpos;
    int vpos;
    int hvel;
    int vvel;
    int eh;
    int ev;
    int ehc;
    int evc;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int hpos_of(input int i);
    return int'(obj_hpos[i*COORD_W +: COORD_W]);
  endfunction

  function automatic int vpos_of(input int i);
    return int'(obj_vpos[i*COORD_W +: COORD_W]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic cfg_write(input int idx, input int hp, input int vp, input int hv, input int vv);
    int ok;
    ok = 0;
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_idx   = 3'(idx);
    cfg_bus.cfg_hpos  = COORD_W'(hp);
    cfg_bus.cfg_vpos  = COORD_W'(vp);
    cfg_bus.cfg_hvel  = COORD_W'(hv);
    cfg_bus.cfg_vvel  = COORD_W'(vv);
    for (int k = 0; k < 40 && ok == 0; k++) begin
      if (cfg_bus.cfg_ready) ok = 1;
      @(negedge clk);
    end
    cfg_bus.cfg_valid = 1'b0;
    if (ok == 0) check("cfg_accept_timeout", 0, 1);
  endtask

  // Drives npulse one-cycle vsync pulses, one every gap cycles, and watches
  // the outputs for a fixed window long enough for every resulting scan.
  task automatic vsync_frames(input int npulse, input int gap,
                              output int busy_cyc, output int fd_cnt, output int rdy_busy);
    busy_cyc = 0;
    fd_cnt   = 0;
    rdy_busy = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (frame_done) fd_cnt++;
      if (busy && cfg_bus.cfg_ready) rdy_busy++;
      vsync = (c < npulse * gap) && ((c % gap) == 0);
    end
    vsync = 1'b0;
  endtask

  initial begin
    int bc, fc, rb, found;

    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_idx   = '0;
    cfg_bus.cfg_hpos  = '0;
    cfg_bus.cfg_vpos  = '0;
    cfg_bus.cfg_hvel  = '0;
    cfg_bus.cfg_vvel  = '0;

    //            idx hpos vpos hvel vvel   eh   ev  ehc evc
    tbl[0] = '{2, 294, 128,   3,   2, 296, 130, 1, 0};
    tbl[1] = '{1, 128,   1,  -2,  -2, 126,   0, 0, 1};
    tbl[2] = '{0, 290, 289,   6,   6, 296, 295, 1, 0};
    tbl[3] = '{3,   0,   2,  -1,  -2,   0,   0, 1, 0};
    tbl[4] = '{3,  50,  60,   0,   0,  50,  60, 0, 0};
    tbl[5] = '{0, 100, 296,   1,   1, 101, 296, 0, 1};
    tbl[6] = '{2, 511, 295,   1,   1,   0, 296, 0, 1};

    // ---- reset values ----
    do_reset();
    for (int i = 0; i < NUM_OBJ; i++) begin
      check($sformatf("rst_hpos%0d", i), hpos_of(i), 128);
      check($sformatf("rst_vpos%0d", i), vpos_of(i), 128);
    end
    check("rst_hcol", int'(obj_hcol), 0);
    check("rst_vcol", int'(obj_vcol), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_cfg_ready", int'(cfg_bus.cfg_ready), 1);

    // ---- one frame from reset ----
    vsync_frames(1, 2, bc, fc, rb);
    $display("frame after reset: busy=%0d cycles, frame_done=%0d", bc, fc);
    check("frame1_busy_cycles", bc, 9);
    check("frame1_frame_done", fc, 1);
    check("frame1_ready_while_busy", rb, 0);
    for (int i = 0; i < NUM_OBJ; i++) begin
      check($sformatf("frame1_hpos%0d", i), hpos_of(i), 126);
      check($sformatf("frame1_vpos%0d", i), vpos_of(i), 130);
    end
    check("frame1_hcol", int'(obj_hcol), 0);
    check("frame1_vcol", int'(obj_vcol), 0);

    // ---- right-wall bounce on obj 2, out-of-range index ignored ----
    do_reset();
    cfg_write(5, 10, 10, 1, 1);
    cfg_write(2, 294, 128, 3, 2);
    vsync_frames(1, 2, bc, fc, rb);
    $display("obj2 bounce frame: hpos2=%0d hcol=%b", hpos_of(2), obj_hcol);
    check("bounce_hpos2", hpos_of(2), 296);
    check("bounce_hcol2", int'(obj_hcol[2]), 1);
    check("bounce_hpos0", hpos_of(0), 126);
    check("bounce_hpos1", hpos_of(1), 126);
    check("bounce_hpos3", hpos_of(3), 126);
    check("bounce_hcol_others", int'(obj_hcol & 4'b1011), 0);
    vsync_frames(1, 2, bc, fc, rb);
    $display("obj2 follow-up frame: hpos2=%0d hcol=%b", hpos_of(2), obj_hcol);
    check("after_bounce_hpos2", hpos_of(2), 293);
    check("after_bounce_hcol2", int'(obj_hcol[2]), 0);

    // ---- table of single-frame steps ----
    for (int t = 0; t < 7; t++) begin
      cfg_write(tbl[t].idx, tbl[t].hpos, tbl[t].vpos, tbl[t].hvel, tbl[t].vvel);
      vsync_frames(1, 2, bc, fc, rb);
      $display("vec %0d: obj%0d h %0d->%0d v %0d->%0d hcol=%0d vcol=%0d",
               t, tbl[t].idx, tbl[t].hpos, hpos_of(tbl[t].idx),
               tbl[t].vpos, vpos_of(tbl[t].idx),
               obj_hcol[tbl[t].idx], obj_vcol[tbl[t].idx]);
      check($sformatf("vec%0d_hpos", t), hpos_of(tbl[t].idx), tbl[t].eh);
      check($sformatf("vec%0d_vpos", t), vpos_of(tbl[t].idx), tbl[t].ev);
      check($sformatf("vec%0d_hcol", t), int'(obj_hcol[tbl[t].idx]), tbl[t].ehc);
      check($sformatf("vec%0d_vcol", t), int'(obj_vcol[tbl[t].idx]), tbl[t].evc);
      check($sformatf("vec%0d_frame_done", t), fc, 1);
    end

    // ---- three edges two cycles apart: one queued, one lost ----
    do_reset();
    vsync_frames(3, 2, bc, fc, rb);
    $display("triple vsync: busy=%0d cycles, frame_done=%0d, overrun=%0d", bc, fc, overrun);
    check("triple_frame_done", fc, 2);
    check("triple_busy_cycles", bc, 18);
    check("triple_overrun", int'(overrun), 1);
    check("triple_hpos0", hpos_of(0), 124);
    check("triple_vpos3", vpos_of(3), 132);

    // ---- asynchronous reset during COMMIT of obj 1 ----
    do_reset();
    check("reset_clears_overrun", int'(overrun), 0);
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      if (busy) found = 1;
      vsync = (c < 2);
    end
    vsync = 1'b0;
    if (found == 0) check("midscan_busy_timeout", 0, 1);
    repeat (3) @(negedge clk);
    check("midscan_obj0_committed", hpos_of(0), 126);
    reset = 1'b0;
    #1;
    $display("reset asserted mid-scan: hpos0=%0d busy=%0d", hpos_of(0), busy);
    for (int i = 0; i < NUM_OBJ; i++) begin
      check($sformatf("midscan_hpos%0d", i), hpos_of(i), 128);
      check($sformatf("midscan_vpos%0d", i), vpos_of(i), 128);
    end
    check("midscan_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vsync_frames(1, 2, bc, fc, rb);
    $display("frame after mid-scan reset: busy=%0d cycles, frame_done=%0d", bc, fc);
    check("postreset_busy_cycles", bc, 9);
    check("postreset_frame_done", fc, 1);
    check("postreset_hpos1", hpos_of(1), 126);
    check("postreset_vpos2", vpos_of(2), 130);

`ifdef BALL_SCHED_PAUSE_EN
    // ---- pause discards edges seen while idle ----
    do_reset();
    pause = 1'b1;
    vsync_frames(3, 4, bc, fc, rb);
    $display("paused vsync: frame_done=%0d overrun=%0d hpos0=%0d", fc, overrun, hpos_of(0));
    check("pause_frame_done", fc, 0);
    check("pause_overrun", int'(overrun), 0);
    check("pause_hpos0", hpos_of(0), 128);
    check("pause_vpos3", vpos_of(3), 128);
    pause = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
